qs_fetch: RTL and testbench

Instruction fetch stage for the qs sequencer core. It holds the program counter and issues reads to the single-cycle-latency instruction memory. Returned `inst_t` words are buffered and handed to the downstream decode stage, together with their PC, over a valid/accept handshake. The stage stops after fetching a WAIT and restarts on a start request. Taken jumps, calls and returns from execute redirect it and flush it.

---
 rtl/qs_insts_pkg.sv | 38 +++
 rtl/qs_fetch_fifo.sv | 61 ++++++
 rtl/qs_fetch.sv | 123 ++++++++++++
 tb/tb_qs_fetch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qs_insts_pkg.sv
// Shared instruction types for the qs sequencer core, plus the fetch-stage
// state encoding and the WAIT decoder used by qs_fetch.
package qs_insts_pkg;

  typedef logic [7:0]  pc_t;
  typedef logic [15:0] inst_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_JUMP  = 4'h8,
    OP_CALL  = 4'h9,
    OP_RET   = 4'hA,
    OP_CNTRL = 4'hF
  } opcode_t;

  localparam inst_t NOP_INST = 16'h0000;
  localparam int    WAIT_BIT = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fetch_entry_t;

  // A CNTRL word with bit 11 clear halts fetch after itself.
  function automatic logic is_wait(inst_t inst);
    return (opcode_t'(inst[15:12]) == OP_CNTRL) && !inst[WAIT_BIT];
  endfunction

endpackage

// File: rtl/qs_fetch_fifo.sv
// Output buffer of the fetch stage: synchronous FIFO of {pc, inst} entries,
// head visible combinationally, flush has priority over push.
module qs_fetch_fifo
  import qs_insts_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_entry_t                 head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_en;
  logic             pop_en;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_en  = pop && (count != '0);
    push_en = push && ((count != CNT_W'(DEPTH)) || pop_en);
    head    = mem[rd_ptr];
  end

  // NOTE: the storage array has no reset; only pointers and count do, and
  // consumers must qualify the head with count != 0.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/qs_fetch.sv
// Instruction fetch stage: owns the PC, issues single-cycle-latency imem reads,
// buffers responses and hands {pc, inst} to decode; stops after a WAIT.
module qs_fetch
  import qs_insts_pkg::*;
#(
  parameter pc_t RESET_PC   = 8'h00,
  parameter int  FIFO_DEPTH = 3
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start_vld,
  input  pc_t   start_pc,
  input  logic  redirect_vld,
  input  pc_t   redirect_pc,
  output logic  imem_ren,
  output pc_t   imem_raddr,
  input  inst_t imem_rdata,
  output logic  fetch_vld,
  output inst_t fetch_inst,
  output pc_t   fetch_pc,
  input  logic  fetch_accept,
  output logic  busy
);

  localparam int             CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  fetch_state_t     state, state_d;
  pc_t              pc, pc_d;
  logic             infl_vld, infl_vld_d;
  pc_t              infl_pc, infl_pc_d;
  logic             infl_live, infl_live_d;

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             resp_live;
  logic             resp_wait;
  logic             issue;
  logic             pop;

  // Occupancy uses registered count and inflight only, so fetch_accept never
  // reaches imem_ren combinationally.
  always_comb begin
    occ       = {1'b0, count} + (CNT_W + 1)'(infl_vld);
    resp_live = infl_vld && infl_live && !redirect_vld;
    resp_wait = resp_live && is_wait(imem_rdata);
    issue     = (state == FETCH) && (occ < DEPTH_L) && !redirect_vld;
    push_data = '{pc: infl_pc, inst: imem_rdata};
    pop       = fetch_vld && fetch_accept && !redirect_vld;
  end

  // NOTE: every signal is given a default before the branches so this block
  // can never infer a latch.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    infl_vld_d  = issue;
    infl_pc_d   = pc;
    infl_live_d = !resp_wait;
    if (redirect_vld) begin
      state_d = FETCH;
      pc_d    = redirect_pc;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_vld) begin
            state_d = FETCH;
            pc_d    = start_pc;
          end
        end
        FETCH: begin
          if (issue)     pc_d    = pc + 8'd1;
          if (resp_wait) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      infl_vld  <= 1'b0;
      infl_pc   <= '0;
      infl_live <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      infl_vld  <= infl_vld_d;
      infl_pc   <= infl_pc_d;
      infl_live <= infl_live_d;
    end
  end

  qs_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_live),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_vld),
    .count     (count),
    .head      (head)
  );

  // Head fields are forced to NOP/0 when empty so stale storage never leaks.
  always_comb begin
    imem_ren   = issue;
    imem_raddr = pc;
    fetch_vld  = (count != '0);
    fetch_inst = fetch_vld ? head.inst : NOP_INST;
    fetch_pc   = fetch_vld ? head.pc : '0;
    busy       = (state == FETCH) || fetch_vld || infl_vld;
  end

endmodule

// File: tb/tb_qs_fetch.sv
// Self-checking bench for qs_fetch: ROM-backed imem, an in-order delivery
// model checked every cycle, plus directed latency/boundary expectations.
module tb_qs_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_vld = 1'b0;
  logic [7:0]  start_pc = '0;
  logic        redirect_vld = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        imem_ren;
  logic [7:0]  imem_raddr;
  logic [15:0] imem_rdata = '0;
  logic        fetch_vld;
  logic [15:0] fetch_inst;
  logic [7:0]  fetch_pc;
  logic        fetch_accept = 1'b0;
  logic        busy;

  logic [15:0] rom [256];
  int          tests = 0;
  int          fails = 0;

  qs_fetch #(
    .RESET_PC   (8'h00),
    .FIFO_DEPTH (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_vld    (start_vld),
    .start_pc     (start_pc),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .imem_ren     (imem_ren),
    .imem_raddr   (imem_raddr),
    .imem_rdata   (imem_rdata),
    .fetch_vld    (fetch_vld),
    .fetch_inst   (fetch_inst),
    .fetch_pc     (fetch_pc),
    .fetch_accept (fetch_accept),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Single-cycle-latency instruction memory; output holds when not read.
  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= rom[imem_raddr];
  end

  function automatic logic tb_is_wait(logic [15:0] i);
    return (i[15:12] == 4'hF) && !i[11];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Program-order model: after a start/redirect, PCs must be delivered
  // consecutively up to and including the first WAIT, then nothing more.
  logic       m_active = 1'b0;
  logic [7:0] m_pc = '0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_pc = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("head_hold_vld", 32'(fetch_vld), 32'd1);
        check("head_hold_pc", 32'(fetch_pc), 32'(prev_pc));
      end
      if (!m_active) check("no_live_delivery", 32'(fetch_vld), 32'd0);
      if (redirect_vld) begin
        m_active  = 1'b1;
        m_pc      = redirect_pc;
        prev_hold = 1'b0;
      end else begin
        if (fetch_vld && fetch_accept && m_active) begin
          check("order_pc", 32'(fetch_pc), 32'(m_pc));
          check("order_inst", 32'(fetch_inst), 32'(rom[m_pc]));
          if (tb_is_wait(rom[m_pc])) m_active = 1'b0;
          m_pc = m_pc + 8'd1;
        end
        prev_hold = fetch_vld && !fetch_accept;
        prev_pc   = fetch_pc;
        if (start_vld && !m_active) begin
          m_active = 1'b1;
          m_pc     = start_pc;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ren"}, 32'(imem_ren), 32'd0);
    check({tag, "_raddr"}, 32'(imem_raddr), 32'h00);
    check({tag, "_vld"}, 32'(fetch_vld), 32'd0);
    check({tag, "_inst"}, 32'(fetch_inst), 32'h0000);
    check({tag, "_pc"}, 32'(fetch_pc), 32'h00);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic pulse_start(input logic [7:0] target);
    start_vld = 1'b1;
    start_pc  = target;
    tick();
    start_vld = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
    rom[8'h10] = 16'h0000; rom[8'h11] = 16'h0000;
    rom[8'h12] = 16'h0000; rom[8'h13] = 16'hF000;
    rom[8'hFE] = 16'h0000; rom[8'hFF] = 16'h0000;
    rom[8'h00] = 16'h0000; rom[8'h01] = 16'hF000;
    rom[8'h30] = 16'hF000;
    rom[8'h52] = 16'hF800;
    rom[8'h54] = 16'hF000;

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Start at 0x10: NOP NOP NOP WAIT, accept held high.
    fetch_accept = 1'b1;
    pulse_start(8'h10);
    tick();
    tick();
    check("t1_vld_t3", 32'(fetch_vld), 32'd1);
    check("t1_pc_t3", 32'(fetch_pc), 32'h10);
    tick(); check("t1_pc_t4", 32'(fetch_pc), 32'h11);
    tick(); check("t1_pc_t5", 32'(fetch_pc), 32'h12);
    tick();
    check("t1_pc_t6", 32'(fetch_pc), 32'h13);
    check("t1_inst_wait", 32'(fetch_inst), 32'hF000);
    tick();
    check("t1_vld_after_wait", 32'(fetch_vld), 32'd0);
    check("t1_busy_after_wait", 32'(busy), 32'd0);
    repeat (3) tick();
    check("t1_no_0x14", 32'(fetch_vld), 32'd0);

    // Stream from 0x20 with decode stalled for five cycles.
    fetch_accept = 1'b0;
    pulse_start(8'h20);
    repeat (4) tick();
    check("t2_ren_stopped", 32'(imem_ren), 32'd0);
    check("t2_raddr", 32'(imem_raddr), 32'h23);
    check("t2_head_vld", 32'(fetch_vld), 32'd1);
    check("t2_head_pc", 32'(fetch_pc), 32'h20);
    fetch_accept = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_gapless", 32'(fetch_vld), 32'd1);
    end

    // Redirect to 0x40 while a read is in flight.
    check("t3_read_in_flight", 32'(imem_ren), 32'd1);
    redirect_vld = 1'b1;
    redirect_pc  = 8'h40;
    #1;
    check("t3_ren_blocked", 32'(imem_ren), 32'd0);
    tick();
    redirect_vld = 1'b0;
    check("t3_flushed_t1", 32'(fetch_vld), 32'd0);
    tick();
    check("t3_flushed_t2", 32'(fetch_vld), 32'd0);
    tick();
    check("t3_vld_t3", 32'(fetch_vld), 32'd1);
    check("t3_pc_t3", 32'(fetch_pc), 32'h40);

    // A start request while fetching is ignored.
    pulse_start(8'h70);
    repeat (5) tick();

    // Reset pulse mid-stream.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_vld", 32'(fetch_vld), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
    end

    // PC wrap 0xFE -> 0xFF -> 0x00.
    pulse_start(8'hFE);
    tick();
    tick();
    check("t4_pc_fe", 32'(fetch_pc), 32'hFE);
    tick(); check("t4_pc_ff", 32'(fetch_pc), 32'hFF);
    tick(); check("t4_pc_00", 32'(fetch_pc), 32'h00);
    wait_idle();

    // WAIT held in the FIFO while idle; redirect and start together.
    fetch_accept = 1'b0;
    pulse_start(8'h30);
    tick();
    tick();
    check("t5_wait_head", 32'(fetch_pc), 32'h30);
    tick();
    check("t5_idle_no_issue", 32'(imem_ren), 32'd0);
    check("t5_wait_held", 32'(fetch_vld), 32'd1);
    check("t5_busy_held", 32'(busy), 32'd1);
    redirect_vld = 1'b1;
    redirect_pc  = 8'h50;
    start_vld    = 1'b1;
    start_pc     = 8'h60;
    fetch_accept = 1'b1;
    tick();
    redirect_vld = 1'b0;
    start_vld    = 1'b0;
    check("t5_wait_flushed", 32'(fetch_vld), 32'd0);
    tick();
    tick();
    check("t5_vld_t3", 32'(fetch_vld), 32'd1);
    check("t5_pc_t3", 32'(fetch_pc), 32'h50);
    wait_idle();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
